// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch front end.
// Holds architectural widths, the reset PC, the sequential PC step and the
// packed {pc, instr} entry type carried through the fetch buffer.
package cpu_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_0000_0000;
    localparam logic [XLEN-1:0] PC_INC           = 64'h0000_0000_0000_0004;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Instructions are word aligned; the two low address bits are discarded.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~64'h0000_0000_0000_0003;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO of fetch entries.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   push, wdata - write request and entry; ignored when full unless popping
//   pop         - read request; ignored when empty
//   flush       - synchronous clear of all entries (wins over push/pop)
//   full, empty - occupancy status
//   head        - oldest entry, all zeros while empty
module ifetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t wdata,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t         mem_r [DEPTH];
    logic [PW-1:0]        wr_ptr_r;
    logic [PW-1:0]        rd_ptr_r;
    logic [CW-1:0]        count_r;
    logic                 do_push_s;
    logic                 do_pop_s;

    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});

    // Qualify requests; a push into a full buffer is legal only alongside a pop,
    // in which case the freed slot is the one being written.
    always_comb begin
        do_pop_s  = 1'b0;
        do_push_s = 1'b0;
        if (flush) begin
            do_pop_s  = 1'b0;
            do_push_s = 1'b0;
        end else begin
            do_pop_s  = pop & ~empty;
            do_push_s = push & (~full | do_pop_s);
        end
    end

    // Head is masked so that consumers see zeros when nothing is buffered.
    always_comb begin
        head = {$bits(fetch_entry_t){1'b0}};
        if (!empty) begin
            head = mem_r[rd_ptr_r];
        end else begin
            head = {$bits(fetch_entry_t){1'b0}};
        end
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {$bits(fetch_entry_t){1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end.
// Drives the PC into a combinational instruction memory, buffers returned
// {pc, instr} pairs and presents them to decode over valid/ready. A redirect
// flushes the buffer and restarts fetch at the (word aligned) new PC.
// Ports:
//   clk, rst_n                  - clock and asynchronous active-low reset
//   imem_pc / imem_instr        - instruction memory address and returned word
//   redirect_valid, redirect_pc - one-cycle fetch restart request and target
//   out_valid/out_instr/out_pc  - head of the fetch buffer towards decode
//   out_ready                   - decode accepts the head this cycle
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    input  logic        out_ready
);

    logic [XLEN-1:0] pc_r;
    logic            full_s;
    logic            empty_s;
    logic            pop_s;
    logic            push_s;
    fetch_entry_t    wdata_s;
    fetch_entry_t    head_s;

    assign imem_pc   = pc_r;
    assign out_valid = ~empty_s;
    assign out_instr = head_s.instr;
    assign out_pc    = head_s.pc;
    assign wdata_s   = '{pc: pc_r, instr: imem_instr};

    // A redirect suppresses both handshakes: the presented head is flushed,
    // not consumed, and nothing from the stale path is fetched.
    always_comb begin
        pop_s  = 1'b0;
        push_s = 1'b0;
        if (redirect_valid) begin
            pop_s  = 1'b0;
            push_s = 1'b0;
        end else begin
            pop_s  = ~empty_s & out_ready;
            push_s = ~full_s | pop_s;
        end
    end

    // Fetch PC: restart on redirect, step on every accepted fetch, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else if (redirect_valid) begin
            pc_r <= align_pc(redirect_pc);
        end else if (push_s) begin
            pc_r <= pc_r + PC_INC;
        end else begin
            pc_r <= pc_r;
        end
    end

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .wdata (wdata_s),
        .pop   (pop_s),
        .flush (redirect_valid),
        .full  (full_s),
        .empty (empty_s),
        .head  (head_s)
    );

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit.
module tb_ifetch_unit;

    logic        clk;
    logic        rst_n;
    logic [63:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_ready;

    int vec_cnt;
    int err_cnt;

    ifetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    // Instruction memory model: word = 0x13 + pc (low 32 bits).
    assign imem_instr = 32'h0000_0013 + imem_pc[31:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, check the reset state, then release.
    task automatic apply_reset(input logic ready);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        out_ready      = ready;
        step();
        step();
        vec_cnt++;
        if (out_valid !== 1'b0 || out_pc !== 64'h0 || out_instr !== 32'h0 || imem_pc !== 64'h0) begin
            err_cnt++;
            $display("FAIL reset_state: valid=%b pc=%h instr=%h imem_pc=%h, want 0/0/0/0",
                     out_valid, out_pc, out_instr, imem_pc);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset(1'b0);
    endtask

    task automatic test_stream();
        apply_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            vec_cnt++;
            if (out_valid !== 1'b1 || out_pc !== 64'(4 * i) || out_instr !== 32'(32'h13 + 4 * i)) begin
                err_cnt++;
                $display("FAIL stream[%0d]: valid=%b pc=%h instr=%h, want 1/%h/%h",
                         i, out_valid, out_pc, out_instr, 64'(4 * i), 32'(32'h13 + 4 * i));
            end
        end
    endtask

    task automatic test_stall();
        apply_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            vec_cnt++;
            if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_instr !== 32'h13) begin
                err_cnt++;
                $display("FAIL stall_hold[%0d]: valid=%b pc=%h instr=%h, want 1/0/00000013",
                         i, out_valid, out_pc, out_instr);
            end
        end
        vec_cnt++;
        if (imem_pc !== 64'h8) begin
            err_cnt++;
            $display("FAIL stall_imem_pc: got %h want 8", imem_pc);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vec_cnt++;
            if (out_valid !== 1'b1 || out_pc !== 64'(4 * i)) begin
                err_cnt++;
                $display("FAIL stall_drain[%0d]: valid=%b pc=%h, want 1/%h",
                         i, out_valid, out_pc, 64'(4 * i));
            end
            step();
        end
    endtask

    task automatic test_redirect();
        apply_reset(1'b0);
        step();
        step();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        step();
        redirect_valid = 1'b0;
        vec_cnt++;
        if (out_valid !== 1'b0 || imem_pc !== 64'h100) begin
            err_cnt++;
            $display("FAIL redir_flush: valid=%b imem_pc=%h, want 0/100", out_valid, imem_pc);
        end
        step();
        vec_cnt++;
        if (out_valid !== 1'b1 || out_pc !== 64'h100 || out_instr !== 32'h113) begin
            err_cnt++;
            $display("FAIL redir_first: valid=%b pc=%h instr=%h, want 1/100/113",
                     out_valid, out_pc, out_instr);
        end
        step();
        vec_cnt++;
        if (out_valid !== 1'b1 || out_pc !== 64'h104 || out_instr !== 32'h117) begin
            err_cnt++;
            $display("FAIL redir_second: valid=%b pc=%h instr=%h, want 1/104/117",
                     out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h203;
        step();
        redirect_valid = 1'b0;
        vec_cnt++;
        if (imem_pc !== 64'h200) begin
            err_cnt++;
            $display("FAIL misalign_imem_pc: got %h want 200", imem_pc);
        end
        step();
        vec_cnt++;
        if (out_valid !== 1'b1 || out_pc !== 64'h200 || out_instr !== 32'h213) begin
            err_cnt++;
            $display("FAIL misalign_out: valid=%b pc=%h instr=%h, want 1/200/213",
                     out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_back_to_back();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        step();
        redirect_pc    = 64'h80;
        step();
        redirect_valid = 1'b0;
        vec_cnt++;
        if (out_valid !== 1'b0 || imem_pc !== 64'h80) begin
            err_cnt++;
            $display("FAIL b2b_flush: valid=%b imem_pc=%h, want 0/80", out_valid, imem_pc);
        end
        step();
        vec_cnt++;
        if (out_valid !== 1'b1 || out_pc !== 64'h80 || out_instr !== 32'h93) begin
            err_cnt++;
            $display("FAIL b2b_first: valid=%b pc=%h instr=%h, want 1/80/93",
                     out_valid, out_pc, out_instr);
        end
        step();
        vec_cnt++;
        if (out_pc !== 64'h84) begin
            err_cnt++;
            $display("FAIL b2b_second: got %h want 84", out_pc);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step();
        vec_cnt++;
        if (out_valid !== 1'b1 || out_pc !== 64'hFFFF_FFFF_FFFF_FFFC || out_instr !== 32'h0000_000F) begin
            err_cnt++;
            $display("FAIL wrap_top: valid=%b pc=%h instr=%h, want 1/fffffffffffffffc/0000000f",
                     out_valid, out_pc, out_instr);
        end
        step();
        vec_cnt++;
        if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_instr !== 32'h13) begin
            err_cnt++;
            $display("FAIL wrap_zero: valid=%b pc=%h instr=%h, want 1/0/13",
                     out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_reset_mid();
        step();
        step();
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (out_valid !== 1'b0 || imem_pc !== 64'h0 || out_pc !== 64'h0) begin
            err_cnt++;
            $display("FAIL reset_mid: valid=%b imem_pc=%h pc=%h, want 0/0/0",
                     out_valid, imem_pc, out_pc);
        end
        step();
        rst_n = 1'b1;
        step();
        vec_cnt++;
        if (out_valid !== 1'b1 || out_pc !== 64'h0) begin
            err_cnt++;
            $display("FAIL reset_mid_restart: valid=%b pc=%h, want 1/0", out_valid, out_pc);
        end
    endtask

    initial begin
        vec_cnt        = 0;
        err_cnt        = 0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        out_ready      = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_misaligned();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
